conv_seq_ctrl: RTL and testbench

CONV_SEQ_CTRL -- requirements
Module: conv_seq_ctrl

---
 rtl/conv_seq_ctrl.sv | 153 +++++++++++++++
 tb/tb_conv_seq_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: sequencer for a column-buffered convolution engine.
// It loads N+2 image columns into the column memories, then streams one
// column of reads to the convolution lanes. Later blocks reload only N
// columns because the two overlap columns are kept, and a frame ends after
// the requested number of column blocks.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   i_start    one-cycle frame start request (sampled in IDLE only)
//   i_imgLen   rows per column, latched at start (must be >= 3)
//   i_nBlocks  column blocks per frame, latched at start (must be != 0)
//   i_valid    host pixel valid
//   i_ready    downstream accepts a convolution read
//   o_ready    pixel accepted this cycle when i_valid=1 (LOAD only)
//   o_WAddr    column-memory write address (row counter)
//   o_RAddr    column-memory read address (read counter)
//   o_sop      first pixel of a column, on the accepted pixel
//   o_eop      last pixel of a column, on the accepted pixel
//   o_chblk    one-cycle block-change pulse
//   o_rdEn     o_RAddr is valid and consumed this cycle
//   o_busy     high whenever the sequencer is not idle
//   o_done     one-cycle frame-complete pulse
module conv_seq_ctrl #(
    parameter int N         = 2,
    parameter int BITS_ADDR = 10,
    parameter int BITS_BLK  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [BITS_ADDR-1:0] i_imgLen,
    input  logic [BITS_BLK-1:0]  i_nBlocks,
    input  logic                 i_valid,
    input  logic                 i_ready,
    output logic                 o_ready,
    output logic [BITS_ADDR-1:0] o_WAddr,
    output logic [BITS_ADDR-1:0] o_RAddr,
    output logic                 o_sop,
    output logic                 o_eop,
    output logic                 o_chblk,
    output logic                 o_rdEn,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int CW = $clog2(N + 3);
    localparam logic [BITS_ADDR-1:0] ONE_A   = BITS_ADDR'(1);
    localparam logic [BITS_ADDR-1:0] MIN_LEN = BITS_ADDR'(3);
    localparam logic [BITS_BLK-1:0]  ONE_B   = BITS_BLK'(1);
    localparam logic [CW-1:0]        ONE_C   = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CONV,
        S_CHBLK,
        S_DONE
    } state_t;

    state_t               state;
    logic [BITS_ADDR-1:0] img_len;
    logic [BITS_BLK-1:0]  n_blk;
    logic [BITS_ADDR-1:0] row;
    logic [BITS_ADDR-1:0] rd;
    logic [BITS_BLK-1:0]  blk;
    logic [CW-1:0]        col;

    logic [CW-1:0]        col_target;
    logic                 last_row;
    logic                 last_rd;
    logic                 in_load;
    logic                 in_conv;

    // The first block of a frame has no retained overlap columns.
    assign col_target = (blk == '0) ? CW'(N + 2) : CW'(N);
    assign last_row   = (row == img_len - ONE_A);
    assign last_rd    = (rd == img_len - ONE_A);
    assign in_load    = (state == S_LOAD);
    assign in_conv    = (state == S_CONV);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            img_len <= '0;
            n_blk   <= '0;
            row     <= '0;
            rd      <= '0;
            blk     <= '0;
            col     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_start && (i_imgLen >= MIN_LEN) && (i_nBlocks != '0)) begin
                        img_len <= i_imgLen;
                        n_blk   <= i_nBlocks;
                        row     <= '0;
                        rd      <= '0;
                        blk     <= '0;
                        col     <= '0;
                        state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (i_valid) begin
                        row <= last_row ? '0 : row + ONE_A;
                        if (last_row) begin
                            col <= col + ONE_C;
                            if (col + ONE_C == col_target) begin
                                state <= S_CONV;
                            end
                        end
                    end
                end
                S_CONV: begin
                    if (i_ready) begin
                        if (last_rd) begin
                            rd    <= '0;
                            state <= S_CHBLK;
                        end else begin
                            rd <= rd + ONE_A;
                        end
                    end
                end
                S_CHBLK: begin
                    blk   <= blk + ONE_B;
                    row   <= '0;
                    col   <= '0;
                    rd    <= '0;
                    state <= (blk + ONE_B == n_blk) ? S_DONE : S_LOAD;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs come from registered state; only the handshake inputs qualify them.
    assign o_ready = in_load;
    assign o_WAddr = row;
    assign o_RAddr = rd;
    assign o_sop   = in_load && i_valid && (row == '0);
    assign o_eop   = in_load && i_valid && last_row;
    assign o_chblk = (state == S_CHBLK);
    assign o_rdEn  = in_conv && i_ready;
    assign o_busy  = (state != S_IDLE);
    assign o_done  = (state == S_DONE);

endmodule

// File: tb/tb_conv_seq_ctrl.sv
module tb_conv_seq_ctrl;

    localparam int N = 2;
    localparam int BA = 10;
    localparam int BB = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start;
    logic [BA-1:0] i_imgLen;
    logic [BB-1:0] i_nBlocks;
    logic          i_valid;
    logic          i_ready;
    logic          o_ready;
    logic [BA-1:0] o_WAddr;
    logic [BA-1:0] o_RAddr;
    logic          o_sop;
    logic          o_eop;
    logic          o_chblk;
    logic          o_rdEn;
    logic          o_busy;
    logic          o_done;

    conv_seq_ctrl #(.N(N), .BITS_ADDR(BA), .BITS_BLK(BB)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_imgLen(i_imgLen),
        .i_nBlocks(i_nBlocks), .i_valid(i_valid), .i_ready(i_ready),
        .o_ready(o_ready), .o_WAddr(o_WAddr), .o_RAddr(o_RAddr),
        .o_sop(o_sop), .o_eop(o_eop), .o_chblk(o_chblk), .o_rdEn(o_rdEn),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Expected event stream of one frame: 1=write pixel, 2=read, 3=chblk, 4=done
    typedef struct {
        int kind;
        int addr;
        bit sop;
        bit eop;
    } ev_t;

    ev_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic ev_t pop_ev();
        ev_t e;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = '{0, 0, 1'b0, 1'b0};
        return e;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, o_ready, 0);
        chk({tag, "_waddr"}, o_WAddr, 0);
        chk({tag, "_raddr"}, o_RAddr, 0);
        chk({tag, "_sop"},   o_sop, 0);
        chk({tag, "_eop"},   o_eop, 0);
        chk({tag, "_chblk"}, o_chblk, 0);
        chk({tag, "_rden"},  o_rdEn, 0);
        chk({tag, "_busy"},  o_busy, 0);
        chk({tag, "_done"},  o_done, 0);
    endtask

    // mode 0: valid/ready always 1; mode 1: alternating; mode 2: random.
    // noise: random i_start and config values while busy (must be ignored).
    task automatic run_frame(input int img, input int nb, input int mode, input bit noise);
        ev_t e;
        int last_rd_cyc = -10;
        int chblk_cyc = -10;
        int budget;
        bit fin = 0;
        exp_q.delete();
        for (int b = 0; b < nb; b++) begin
            int cols = (b == 0) ? N + 2 : N;
            for (int k = 0; k < cols * img; k++)
                exp_q.push_back('{1, k % img, (k % img) == 0, (k % img) == img - 1});
            for (int r = 0; r < img; r++) exp_q.push_back('{2, r, 1'b0, 1'b0});
            exp_q.push_back('{3, 0, 1'b0, 1'b0});
        end
        exp_q.push_back('{4, 0, 1'b0, 1'b0});
        budget = nb * (N + 2) * img * 6 + 50;

        @(negedge clk);
        i_start = 1; i_imgLen = BA'(img); i_nBlocks = BB'(nb);
        i_valid = 0; i_ready = 0;
        for (int cyc = 0; !fin && cyc < budget; cyc++) begin
            @(negedge clk);
            i_start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noise) begin
                i_imgLen  = BA'($urandom_range(0, 15));
                i_nBlocks = BB'($urandom_range(0, 7));
            end
            case (mode)
                0: begin i_valid = 1; i_ready = 1; end
                1: begin i_valid = (cyc % 2 == 0); i_ready = (cyc % 2 == 1); end
                default: begin
                    i_valid = ($urandom_range(0, 3) != 0);
                    i_ready = ($urandom_range(0, 3) != 0);
                end
            endcase
            #1;
            chk("busy", o_busy, 1);
            if (o_ready && i_valid) begin
                e = pop_ev();
                chk("wr_kind", e.kind, 1);
                chk("waddr", o_WAddr, e.addr);
                chk("sop", o_sop, e.sop);
                chk("eop", o_eop, e.eop);
            end else begin
                chk("no_sop_eop", {o_sop, o_eop}, 0);
            end
            if (o_rdEn) begin
                e = pop_ev();
                chk("rd_kind", e.kind, 2);
                chk("raddr", o_RAddr, e.addr);
                last_rd_cyc = cyc;
            end else if (!o_ready && !o_chblk && !o_done && exp_q.size() > 0 && exp_q[0].kind == 2) begin
                chk("raddr_hold", o_RAddr, exp_q[0].addr);
            end
            if (o_chblk) begin
                e = pop_ev();
                chk("chblk_kind", e.kind, 3);
                chk("chblk_after_rd", cyc, last_rd_cyc + 1);
                chblk_cyc = cyc;
            end
            if (o_done) begin
                e = pop_ev();
                chk("done_kind", e.kind, 4);
                chk("done_after_chblk", cyc, chblk_cyc + 1);
                fin = 1;
            end
        end
        chk("frame_finished", fin, 1);
        @(negedge clk);
        i_start = 0; i_valid = 0; i_ready = 0;
        #1;
        chk("idle_after_done", o_busy, 0);
        chk("done_one_cycle", o_done, 0);
        chk("events_left", exp_q.size(), 0);
    endtask

    task automatic try_bad(input int img, input int nb);
        @(negedge clk);
        i_start = 1; i_imgLen = BA'(img); i_nBlocks = BB'(nb); i_valid = 1; i_ready = 1;
        @(negedge clk);
        i_start = 0;
        #1 chk("bad_start_busy", o_busy, 0);
        @(negedge clk);
        #1 chk("bad_start_busy2", o_busy, 0);
        i_valid = 0; i_ready = 0;
    endtask

    initial begin
        bit hit = 0;
        rst = 1; i_start = 0; i_imgLen = '0; i_nBlocks = '0; i_valid = 1; i_ready = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 chk_all_zero("reset");
        i_valid = 0; i_ready = 0;
        rst = 0;

        run_frame(4, 1, 0, 0);
        run_frame(4, 3, 0, 0);
        run_frame(4, 2, 1, 0);
        try_bad(2, 1);
        try_bad(4, 0);
        try_bad(0, 3);
        run_frame(5, 2, 2, 1);

        // reset mid-LOAD once the write address reaches 2
        @(negedge clk);
        i_start = 1; i_imgLen = BA'(5); i_nBlocks = BB'(2); i_valid = 0; i_ready = 0;
        for (int c = 0; c < 20 && !hit; c++) begin
            @(negedge clk);
            i_start = 0; i_valid = 1; i_ready = 1;
            #1 if (o_WAddr == 2) hit = 1;
        end
        chk("waddr_reached_2", hit, 1);
        rst = 1;
        @(negedge clk);
        #1 chk_all_zero("mid_reset");
        // reset wins over a simultaneous start
        i_start = 1; i_imgLen = BA'(4); i_nBlocks = BB'(1);
        @(negedge clk);
        rst = 0; i_start = 0; i_valid = 0; i_ready = 0;
        #1 chk("rst_over_start", o_busy, 0);

        run_frame(4, 1, 0, 0);
        for (int f = 0; f < 6; f++)
            run_frame($urandom_range(3, 8), $urandom_range(1, 3), 2, 1'($urandom_range(0, 1)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
